// File: rtl/dht_pkg.sv
// Shared types and helpers for the single-wire DHT11/DHT22 sensor controller.
// Combinational definitions only: no latency, no flow control.
package dht_pkg;

  localparam int US_CNT_W   = 16;
  localparam int FRAME_BITS = 40;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_ACK,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_FAIL_TO
  } state_t;

  typedef struct packed {
    logic [15:0] rh;
    logic [15:0] t;
    logic [7:0]  ck;
  } frame_t;

  function automatic int us_to_ticks(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  // Modulo-256 sum of the four payload bytes.
  function automatic logic [7:0] sum8(input logic [31:0] b);
    return b[31:24] + b[23:16] + b[15:8] + b[7:0];
  endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Prescaler: one-cycle 1 us strobe from core clock, and a 1 ms strobe every 1000 us strobes.
// Strobes are combinational from the counters; free-running, no backpressure.
module dht_us_tick
  import dht_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick,
  output logic ms_tick
);

  localparam int DIV   = us_to_ticks(CLK_HZ, 1);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       ms_cnt;

  always_comb us_tick = (div_cnt == DIV_W'(DIV - 1));
  always_comb ms_tick = us_tick && (ms_cnt == 10'd999);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      div_cnt <= us_tick ? '0 : div_cnt + 1'b1;
      if (us_tick) ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 controller: start pulse, response timing, 40-bit decode, checksum and timeout report.
// done/valid 2 cycles after the final synchronised falling edge; triggers while busy are dropped.
module dht_reader
  import dht_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int START_LOW_US  = 1000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int POLL_MS       = 2000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dht_in,
  output logic                  dht_oe,
  output logic [FRAME_BITS-1:0] data,
  output logic                  valid,
  output logic                  done,
  output logic                  crc_err,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int POLL_W = (POLL_MS > 1) ? $clog2(POLL_MS) : 1;
  localparam logic [US_CNT_W-1:0] START_TICKS  = US_CNT_W'(START_LOW_US);
  localparam logic [US_CNT_W-1:0] THRESH_TICKS = US_CNT_W'(BIT_THRESH_US);
  localparam logic [US_CNT_W-1:0] TMO_TICKS    = US_CNT_W'(TIMEOUT_US);

  logic us_tick, ms_tick;

  dht_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .us_tick (us_tick),
    .ms_tick (ms_tick)
  );

  // Bus idles high, so the sync chain resets to 1 to avoid a phantom edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_q;
  logic                   in_s, rise, fall;

  always_comb begin
    in_s = sync_q[SYNC_STAGES-1];
    rise = in_s & ~in_q;
    fall = ~in_s & in_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      in_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dht_in};
      in_q   <= in_s;
    end
  end

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_exp;

  always_comb poll_exp = (POLL_MS != 0) && ms_tick && (poll_cnt == POLL_W'(POLL_MS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         poll_cnt <= '0;
    else if (ms_tick) poll_cnt <= poll_exp ? '0 : poll_cnt + 1'b1;
  end

  state_t              state, state_nxt;
  logic [US_CNT_W-1:0] us_cnt;
  logic [5:0]          bit_cnt;
  frame_t              frame;
  logic                tmo;

  always_comb tmo = (us_cnt >= TMO_TICKS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start || poll_exp) state_nxt = S_START_LOW;
      S_START_LOW: if (us_cnt >= START_TICKS) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (fall) state_nxt = S_RESP_LOW;  else if (tmo) state_nxt = S_FAIL_TO;
      S_RESP_LOW:  if (rise) state_nxt = S_RESP_HIGH; else if (tmo) state_nxt = S_FAIL_TO;
      S_RESP_HIGH: if (fall) state_nxt = S_BIT_LOW;   else if (tmo) state_nxt = S_FAIL_TO;
      S_BIT_LOW:   if (rise) state_nxt = S_BIT_HIGH;  else if (tmo) state_nxt = S_FAIL_TO;
      S_BIT_HIGH: begin
        if (fall)     state_nxt = (bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
        else if (tmo) state_nxt = S_FAIL_TO;
      end
      S_CHECK:     state_nxt = S_IDLE;
      S_FAIL_TO:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dht_oe = (state == S_START_LOW);
    busy   = (state != S_IDLE);
  end

  // The counter restarts on every state change and includes the tick of the edge
  // cycle itself, so a high phase of N us reads back as N at its falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      us_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      if (state_nxt != state)          us_cnt <= {{(US_CNT_W-1){1'b0}}, us_tick};
      else if (us_tick && us_cnt != '1) us_cnt <= us_cnt + 1'b1;
      if (state == S_RESP_HIGH && fall) bit_cnt <= '0;
      if (state == S_BIT_HIGH && fall) begin
        frame   <= {frame[FRAME_BITS-2:0], (us_cnt > THRESH_TICKS)};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == S_CHECK) begin
        done        <= 1'b1;
        timeout_err <= 1'b0;
        if (sum8({frame.rh, frame.t}) == frame.ck) begin
          data    <= frame;
          valid   <= 1'b1;
          crc_err <= 1'b0;
        end else begin
          crc_err <= 1'b1;
        end
      end
      if (state == S_FAIL_TO) begin
        done        <= 1'b1;
        timeout_err <= 1'b1;
        crc_err     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht_reader.sv
// Bench for dht_reader at 1 MHz: table of sensor frames with a result scoreboard,
// plus start-spam, reset and auto-poll sequences on a second instance.
module tb_dht_reader;

  localparam int CLK_HZ       = 1_000_000;
  localparam int START_LOW_US = 1000;

  typedef struct packed {
    logic [39:0] data;
    logic        valid;
    logic        crc;
    logic        to;
  } res_t;

  typedef struct {
    logic [39:0] frame;
    int          hi0;
    int          hi1;
    int          nbits;   // -1: sensor silent
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sen, bus;
  logic        dht_oe, valid, done, crc_err, timeout_err, busy;
  logic [39:0] data;

  logic        rst2, start2, bus2;
  logic        oe2, valid2, done2, crc2, to2, busy2;
  logic [39:0] data2;

  assign bus  = dht_oe ? 1'b0 : sen;
  assign bus2 = ~oe2;

  dht_reader #(.CLK_HZ(CLK_HZ), .START_LOW_US(START_LOW_US), .BIT_THRESH_US(50),
               .TIMEOUT_US(200), .POLL_MS(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dht_in(bus), .dht_oe(dht_oe), .data(data),
    .valid(valid), .done(done), .crc_err(crc_err), .timeout_err(timeout_err), .busy(busy)
  );

  dht_reader #(.CLK_HZ(CLK_HZ), .START_LOW_US(START_LOW_US), .BIT_THRESH_US(50),
               .TIMEOUT_US(200), .POLL_MS(5), .SYNC_STAGES(2)) dut_poll (
    .clk(clk), .rst(rst2), .start(start2), .dht_in(bus2), .dht_oe(oe2), .data(data2),
    .valid(valid2), .done(done2), .crc_err(crc2), .timeout_err(to2), .busy(busy2)
  );

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  bit   poll_done = 1'b0;
  res_t sb[$];
  res_t exp_r;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (valid) check("valid_needs_done", done, 1);
    if (done) begin
      done_cnt++;
      check("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        check("result", {data, valid, crc_err, timeout_err, busy}, {exp_r, 1'b0});
      end
    end
  end

  task automatic sensor_frame(input logic [39:0] f, input int hi0, input int hi1, input int nbits);
    repeat (30) tick();
    sen = 1'b0; repeat (80) tick();
    sen = 1'b1; repeat (80) tick();
    for (int i = 0; i < nbits; i++) begin
      sen = 1'b0; repeat (50) tick();
      sen = 1'b1; repeat (f[39-i] ? hi1 : hi0) tick();
    end
    sen = 1'b0; repeat (50) tick();
    sen = 1'b1;
  endtask

  task automatic spammer();
    repeat (5) tick();
    for (int k = 0; k < 1000 && busy; k++) begin
      start = 1'b1; tick(); start = 1'b0;
      repeat (9) tick();
    end
  endtask

  task automatic run_txn(input vec_t v, input bit spam);
    int d0, n, m;
    d0 = done_cnt;
    sb.push_back(v.exp);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (dht_oe === 1'b1 && n < 4000) begin n++; tick(); end
    check("oe_len", n, START_LOW_US);
    if (v.nbits < 0) begin
      m = 0;
      while (done_cnt == d0 && m < 1000) begin m++; tick(); end
      check("timeout_at_200us", (m >= 199 && m <= 203), 1);
    end else if (spam) begin
      fork
        sensor_frame(v.frame, v.hi0, v.hi1, v.nbits);
        spammer();
      join
    end else begin
      sensor_frame(v.frame, v.hi0, v.hi1, v.nbits);
    end
    m = 0;
    while (done_cnt == d0 && m < 1000) begin m++; tick(); end
    repeat (20) tick();
    check("one_done", done_cnt - d0, 1);
    check("idle_after", {busy, dht_oe}, 0);
  endtask

  function automatic vec_t mk(input logic [39:0] f, input int h0, input int h1, input int nb,
                              input logic [39:0] ed, input logic ev, input logic ec, input logic et);
    vec_t v;
    v.frame = f; v.hi0 = h0; v.hi1 = h1; v.nbits = nb;
    v.exp.data = ed; v.exp.valid = ev; v.exp.crc = ec; v.exp.to = et;
    return v;
  endfunction

  // Auto-poll instance: busy must rise every 5 ms with start tied low.
  initial begin : poll_mon
    int  last, rises;
    logic prev;
    last = 0; rises = 0; prev = 1'b0;
    @(posedge rst2);
    for (int c = 0; c < 30000 && rises < 4; c++) begin
      @(negedge clk);
      if (busy2 && !prev) begin
        if (rises > 0) check("poll_period", cyc - last, 5000);
        last = cyc;
        rises++;
      end
      prev = busy2;
    end
    check("poll_rises", rises, 4);
    poll_done = 1'b1;
  end

  initial begin : main
    vec_t vecs[6];
    int   n;
    vecs[0] = mk(40'h028C015FEE, 26, 70, 40, 40'h028C015FEE, 1, 0, 0);
    vecs[1] = mk(40'h028C015FEF, 26, 70, 40, 40'h028C015FEE, 0, 1, 0);
    vecs[2] = mk(40'h0,          26, 70, -1, 40'h028C015FEE, 0, 0, 1);
    vecs[3] = mk(40'h1E0A00F21A, 26, 70, 17, 40'h028C015FEE, 0, 0, 1);
    vecs[4] = mk(40'h1E0A00F21A, 26, 70, 40, 40'h1E0A00F21A, 1, 0, 0);
    vecs[5] = mk(40'h01F400FAEF, 50, 51, 40, 40'h01F400FAEF, 1, 0, 0);

    rst = 1'b0; rst2 = 1'b0; start = 1'b0; start2 = 1'b0; sen = 1'b1;
    repeat (5) tick();
    check("reset_vals", {dht_oe, data, valid, done, crc_err, timeout_err, busy}, 0);
    rst = 1'b1; rst2 = 1'b1;
    repeat (5) tick();
    check("idle_after_reset", {busy, dht_oe, valid, done}, 0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);

    // start spammed every 10 us while busy: one done, nothing queued.
    run_txn(mk(40'h028C015FEE, 26, 70, 40, 40'h028C015FEE, 1, 0, 0), 1'b1);

    // Asynchronous reset during the host low pulse.
    start = 1'b1; tick(); start = 1'b0;
    repeat (500) tick();
    check("oe_mid_start", dht_oe, 1);
    #3 rst = 1'b0;
    #1 check("rst_async", {dht_oe, data, valid, done, crc_err, timeout_err, busy}, 0);
    tick(); tick();
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (busy || dht_oe) n++;
    end
    check("no_trig_after_rst", n, 0);
    run_txn(vecs[4], 1'b0);

    n = 0;
    while (!poll_done && n < 30000) begin n++; tick(); end
    check("poll_finished", poll_done, 1);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
